// File: rtl/seq_pkg.sv
// Shared types and default sizing for the N-phase timing generator.
package seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_HOLD = 2'd2
    } seq_state_e;

    localparam int SEQ_N_PHASES_DEF = 3;
    localparam int SEQ_DWELL_W_DEF  = 8;
    localparam int SEQ_PRESCALE_DEF = 25000000;

endpackage

// File: rtl/seq_tick_gen.sv
// Tick prescaler: one-clock tick every PRESCALE clocks (counter at PRESCALE-1).
module seq_tick_gen
    import seq_pkg::*;
#(
    parameter int PRESCALE = SEQ_PRESCALE_DEF
) (
    input  logic nRst,
    input  logic clk_out,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TOP = CW'(PRESCALE - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk_out or negedge nRst) begin
        if (!nRst) begin
            count_reg <= '0;
        end else if (count_reg == TOP) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign tick = (count_reg == TOP);

endmodule

// File: rtl/phase_seq_gen.sv
// N-phase one-hot timing generator with per-phase dwell, pause/stop and one-shot.
// Define SEQ_PRESCALE_EN to divide clk_out into ticks via seq_tick_gen.
module phase_seq_gen
    import seq_pkg::*;
#(
    parameter int N_PHASES = SEQ_N_PHASES_DEF,
    parameter int DWELL_W  = SEQ_DWELL_W_DEF,
    parameter int PRESCALE = SEQ_PRESCALE_DEF
) (
    input  logic                          nRst,
    input  logic                          clk_out,
    input  logic                          nSTART,
    input  logic                          nSTOP,
    input  logic                          one_shot,
    input  logic [N_PHASES*DWELL_W-1:0]   dwell,
    output logic [N_PHASES-1:0]           T,
    output logic [$clog2(N_PHASES)-1:0]   phase_idx,
    output logic                          busy,
    output logic                          cycle_done
);

    localparam int PH_W = $clog2(N_PHASES);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(N_PHASES - 1);

    logic tick;

`ifdef SEQ_PRESCALE_EN
    seq_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .nRst    (nRst),
        .clk_out (clk_out),
        .tick    (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick = 1'b1;
`endif

    seq_state_e           state_reg, state_next;
    logic [PH_W-1:0]      phase_reg, phase_next;
    logic [DWELL_W-1:0]   cnt_reg, cnt_next;
    logic [N_PHASES-1:0]  t_reg, t_next;
    logic                 done_reg, done_next;

    logic [DWELL_W-1:0]   dwell_arr [N_PHASES];
    logic                 last_phase;
    logic [PH_W-1:0]      phase_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N_PHASES; gi++) begin : g_dwell
            assign dwell_arr[gi] = dwell[gi*DWELL_W +: DWELL_W];
        end
    endgenerate

    assign last_phase = (phase_reg == LAST_PH);
    assign phase_inc  = last_phase ? '0 : phase_reg + PH_W'(1);

    always_ff @(posedge clk_out or negedge nRst) begin
        if (!nRst) begin
            state_reg <= SEQ_IDLE;
            phase_reg <= '0;
            cnt_reg   <= '0;
            t_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            t_reg     <= t_next;
            done_reg  <= done_next;
        end
    end

    // A HOLD released on a tick falls through into the normal RUN counting
    // so the resume tick is not lost.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        if (tick) begin
            unique case (state_reg)
                SEQ_IDLE: begin
                    if (!nSTART && nSTOP) begin
                        state_next = SEQ_RUN;
                        phase_next = '0;
                        cnt_next   = dwell_arr[0];
                    end
                end
                default: begin
                    if (!nSTOP) begin
                        if (last_phase) begin
                            state_next = SEQ_IDLE;
                            phase_next = '0;
                            cnt_next   = '0;
                        end else begin
                            state_next = SEQ_HOLD;
                        end
                    end else begin
                        state_next = SEQ_RUN;
                        if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - DWELL_W'(1);
                        end else if (!last_phase) begin
                            phase_next = phase_inc;
                            cnt_next   = dwell_arr[phase_inc];
                        end else begin
                            done_next  = 1'b1;
                            phase_next = '0;
                            if (one_shot) begin
                                state_next = SEQ_IDLE;
                                cnt_next   = '0;
                            end else begin
                                cnt_next   = dwell_arr[0];
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        t_next = '0;
        if (state_next != SEQ_IDLE) begin
            t_next[phase_next] = 1'b1;
        end
    end

    assign T          = t_reg;
    assign phase_idx  = phase_reg;
    assign busy       = (state_reg != SEQ_IDLE);
    assign cycle_done = done_reg;

endmodule

// File: tb/tb_phase_seq_gen.sv
// Scoreboard bench for phase_seq_gen: tick-level reference model feeds a queue,
// a monitor compares every clock against the DUT.
module tb_phase_seq_gen;

    localparam int NP  = 3;
    localparam int DW  = 4;
    localparam int DWT = NP * DW;
`ifdef SEQ_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic           clk_out  = 1'b0;
    logic           nRst     = 1'b1;
    logic           nSTART   = 1'b1;
    logic           nSTOP    = 1'b1;
    logic           one_shot = 1'b0;
    logic [DWT-1:0] dwell    = 12'h210;
    logic [NP-1:0]  T;
    logic [1:0]     phase_idx;
    logic           busy;
    logic           cycle_done;

    typedef struct packed {
        logic [NP-1:0] t;
        logic [1:0]    ph;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_out = ~clk_out;

    phase_seq_gen #(
        .N_PHASES (NP),
        .DWELL_W  (DW),
        .PRESCALE (PS)
    ) dut (
        .nRst       (nRst),
        .clk_out    (clk_out),
        .nSTART     (nSTART),
        .nSTOP      (nSTOP),
        .one_shot   (one_shot),
        .dwell      (dwell),
        .T          (T),
        .phase_idx  (phase_idx),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    // Reference model: tracks ticks left in the current phase, latched on entry.
    always begin : model
        int   m_state, m_ph, m_left, m_pc;
        bit   tk, m_done;
        exp_t e;
        @(posedge clk_out or negedge nRst);
        if (!nRst) begin
            m_state = M_IDLE;
            m_ph    = 0;
            m_left  = 0;
            m_pc    = 0;
            sb.delete();
        end else begin
            tk     = (m_pc == PS - 1);
            m_pc   = (m_pc + 1) % PS;
            m_done = 1'b0;
            if (tk) begin
                if (m_state == M_IDLE) begin
                    if (!nSTART && nSTOP) begin
                        m_state = M_RUN;
                        m_ph    = 0;
                        m_left  = int'(dwell[0 +: DW]) + 1;
                    end
                end else if (!nSTOP) begin
                    if (m_ph == NP - 1) begin
                        m_state = M_IDLE;
                        m_ph    = 0;
                    end else begin
                        m_state = M_HOLD;
                    end
                end else begin
                    m_state = M_RUN;
                    m_left  = m_left - 1;
                    if (m_left == 0) begin
                        if (m_ph < NP - 1) begin
                            m_ph   = m_ph + 1;
                            m_left = int'(dwell[m_ph*DW +: DW]) + 1;
                        end else begin
                            m_done = 1'b1;
                            m_ph   = 0;
                            if (one_shot) m_state = M_IDLE;
                            else m_left = int'(dwell[0 +: DW]) + 1;
                        end
                    end
                end
            end
            e.t    = '0;
            if (m_state != M_IDLE) e.t[m_ph] = 1'b1;
            e.ph   = 2'(m_ph);
            e.busy = (m_state != M_IDLE);
            e.done = m_done;
            sb.push_back(e);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always begin : monitor
        exp_t e;
        @(negedge clk_out or negedge nRst);
        #1;
        if (!nRst) begin
            chk("rst_T", int'(T), 0);
            chk("rst_idx", int'(phase_idx), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(cycle_done), 0);
        end else if (sb.size() == 0) begin
            chk("sb_empty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk("T", int'(T), int'(e.t));
            chk("phase_idx", int'(phase_idx), int'(e.ph));
            chk("busy", int'(busy), int'(e.busy));
            chk("cycle_done", int'(cycle_done), int'(e.done));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_out);
            #2;
        end
    endtask

    task automatic do_reset(input int hold);
        nRst = 1'b0;
        repeat (hold) @(posedge clk_out);
        #7;
        nRst = 1'b1;
        @(posedge clk_out);
        #2;
    endtask

    initial begin
        #1;
        do_reset(2);
        cyc(3);
        // Start while stopped must be ignored.
        nSTART = 1'b0; nSTOP = 1'b0;
        cyc(1);
        nSTART = 1'b1; nSTOP = 1'b1;
        cyc(3);
        // Continuous run, then a 4-cycle pause at the start of phase 1.
        nSTART = 1'b0;
        cyc(1);
        nSTART = 1'b1;
        cyc(7);
        nSTOP = 1'b0;
        cyc(4);
        nSTOP = 1'b1;
        cyc(2);
        // Stop inside the last phase, then restart as one-shot.
        nSTOP = 1'b0;
        cyc(1);
        nSTOP = 1'b1;
        cyc(3);
        one_shot = 1'b1;
        nSTART = 1'b0;
        cyc(1);
        nSTART = 1'b1;
        cyc(10);
        // Async reset in the first cycle of phase 1.
        one_shot = 1'b0;
        nSTART = 1'b0;
        cyc(1);
        nSTART = 1'b1;
        @(posedge clk_out);
        #3;
        do_reset(2);
        cyc(3);
        for (int i = 0; i < 3000; i++) begin
            nSTART = ($urandom_range(5) != 0);
            nSTOP  = ($urandom_range(9) != 0);
            if ($urandom_range(63) == 0) one_shot = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) dwell = DWT'($urandom);
            if ($urandom_range(999) == 0) do_reset(1);
            else cyc(1);
        end
        nSTART = 1'b1;
        nSTOP  = 1'b1;
        cyc(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_seq_gen.md
# phase_seq_gen

Parametrised N-phase timing generator for the board-level control logic. Produces a one-hot phase strobe sequence T[N_PHASES-1:0] with per-phase programmable dwell, start/pause/stop control, continuous or one-shot operation and a cycle-complete pulse. It extends the fixed three-phase T1→T2→T3 sequencer to arbitrary phase count and dwell, and optionally absorbs the tick prescaler so a fast board clock can be used directly.

## Interface
- N_PHASES, 3, number of phases; must be ≥ 2.
- DWELL_W, 8, width of each per-phase dwell field.
- PRESCALE, 25000000, clocks per tick; used only with SEQ_PRESCALE_EN.
- nRst  in  1  reset, asynchronous, active-low.
- clk_out  in  1  clock; all logic on rising edge.
- nSTART  in  1  active-low start request, synchronous to clk_out.
- nSTOP  in  1  active-low pause/stop, synchronous to clk_out.
- one_shot  in  1  1: stop after one full cycle; 0: wrap continuously.
- dwell  in  N_PHASES*DWELL_W  phase i dwell at [i*DWELL_W +: DWELL_W].
- T  out  N_PHASES  one-hot phase strobe; all-zero when idle.
- phase_idx  out  $clog2(N_PHASES)  index of the active phase.
- busy  out  1  high when not idle.
- cycle_done  out  1  one-clock pulse on normal exit from the last phase.

## Operation
- States: IDLE, RUN, HOLD. Dwell counter cnt is DWELL_W bits wide.
- Phase i lasts dwell[i]+1 ticks; dwell=0 gives 1 tick. dwell[i] is sampled on phase entry; later changes do not affect the active phase.
- Decisions are evaluated only on tick cycles. Priority per tick:
  1. IDLE with nSTART=0 and nSTOP=1: enter RUN, phase 0, cnt=dwell[0]. nSTART while nSTOP=0 is ignored.
  2. RUN/HOLD with nSTOP=0 in the last phase: go to IDLE, T=0. No cycle_done.
  3. RUN/HOLD with nSTOP=0 in any other phase: HOLD. T, phase_idx and cnt are frozen.
  4. HOLD with nSTOP=1: return to RUN and resume the remaining count. The same tick also counts.
  5. RUN with cnt≠0: cnt decrements.
  6. RUN with cnt=0 in a non-last phase: advance to phase+1, cnt=dwell[phase+1].
  7. RUN with cnt=0 in the last phase: pulse cycle_done. If one_shot=1, go to IDLE; otherwise go to phase 0 with cnt=dwell[0].
- nSTART is ignored while busy.
- Outputs are registered. T is always one-hot in RUN/HOLD and zero in IDLE. busy=(state≠IDLE).
- Reset (any time, including mid-run): T=0, phase_idx=0, busy=0, cycle_done=0, cnt=0, state=IDLE, prescaler=0.

## Timing
- Start latency: nSTART sampled low on a tick edge → T[0]=1 after that edge.
- Phase changes, stops and wrap occur on the tick edge where the condition is sampled.
- cycle_done is high for exactly one clk_out cycle, coincident with the first cycle of phase 0 (wrap) or the first IDLE cycle (one-shot).
- Full-cycle length in ticks: Σ(dwell[i]+1).
- No input synchronisers; callers deliver synchronous, debounced inputs.

## Configuration
- SEQ_PRESCALE_EN defined: an internal counter counts 0..PRESCALE-1 and wraps. tick is high for one clock when the counter is at PRESCALE-1. Inputs are sampled only on tick; cycle_done remains one clk_out cycle wide.
- SEQ_PRESCALE_EN undefined: tick is constant 1, PRESCALE is unused and no counter is synthesised.

## Structure
- Package seq_pkg: state enum (SEQ_IDLE, SEQ_RUN, SEQ_HOLD) and default constants for N_PHASES, DWELL_W and PRESCALE.
- Sub-module seq_tick_gen: the prescaler, instantiated only under SEQ_PRESCALE_EN.
- Top level: state register, cnt, and one-hot/index encoding.

## Test plan
All scenarios use N_PHASES=3, DWELL_W=4, dwell phase0=0, phase1=1, phase2=2, and no prescaler unless stated.
- Continuous run: nSTART low for 1 cycle → T = 001, 010, 010, 100, 100, 100, 001… The sequence repeats every 6 cycles. cycle_done pulses on each return to 001.
- One-shot: one_shot=1 with start → 6 cycles of sequence, then T=000 and busy=0. cycle_done pulses once, with the first IDLE cycle.
- Pause: nSTOP low for 4 cycles starting at the first cycle of phase 1 → T=010 is held for 4 extra cycles, then phase 1 completes its remaining tick before 100.
- Stop in last phase: nSTOP low during phase 2 → T=000 on the next edge and no cycle_done. A subsequent nSTART low with nSTOP high restarts at 001.
- Ignored start and async reset: nSTART low with nSTOP low in IDLE → T stays 000. nRst low mid-phase 1 → T=000 and busy=0 immediately, without waiting for a clock edge.
- SEQ_PRESCALE_EN with PRESCALE=4: continuous run → each tick spans 4 clocks, so phase 2 lasts 12 clocks. cycle_done stays 1 clock wide.
